// File: rtl/timer_share_sched.sv
// Round-robin scheduler that shares one Avalon-MM interval timer among NREQ
// one-shot delay requesters; programs, waits, stops and clears the timer per grant.
module timer_share_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 3
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NREQ-1:0]      req,
    input  logic [32*NREQ-1:0]   req_period,
    output logic [NREQ-1:0]      done,
    output logic [NREQ-1:0]      aborted,
    output logic                 busy,
    output logic [IDW-1:0]       active_id,
    output logic [2:0]           tm_address,
    output logic                 tm_chipselect,
    output logic                 tm_write_n,
    output logic [15:0]          tm_writedata,
    input  logic                 tm_irq
);

    typedef enum logic [2:0] {
        S_IDLE, S_WR_PL, S_WR_PH, S_WR_CTL, S_WAIT_IRQ, S_WR_STOP, S_CLR_ST, S_DONE
    } state_t;

    state_t            state_r, state_s;
    logic [IDW-1:0]    rr_ptr_r, rr_ptr_s, id_s, offset_s, grant_id_s;
    logic [IDW:0]      scan_s;
    logic [NREQ-1:0]   req_rot_s, done_s, aborted_s;
    logic [31:0]       period_q_r, period_s, grant_period_s;
    logic              expired_r, expired_s, cur_req_s;
    logic              tm_cs_s, tm_wn_s;
    logic [2:0]        tm_addr_s;
    logic [15:0]       tm_data_s;

    // Round-robin pick: rotate req so the pointer sits at bit 0, take the lowest set bit.
    always_comb begin
        req_rot_s = NREQ'({req, req} >> rr_ptr_r);
        offset_s  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_rot_s[k]) begin
                offset_s = IDW'(k);
            end else begin
                offset_s = offset_s;
            end
        end
        scan_s     = {1'b0, rr_ptr_r} + {1'b0, offset_s};
        grant_id_s = (scan_s >= (IDW+1)'(NREQ)) ? IDW'(scan_s - (IDW+1)'(NREQ))
                                                : scan_s[IDW-1:0];
        grant_period_s = 32'd0;
        cur_req_s      = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_id_s == IDW'(i)) begin
                grant_period_s = req_period[32*i +: 32];
            end else begin
                grant_period_s = grant_period_s;
            end
            if (active_id == IDW'(i)) begin
                cur_req_s = req[i];
            end else begin
                cur_req_s = cur_req_s;
            end
        end
    end

    // Next-state logic; irq takes priority over a same-cycle request drop.
    always_comb begin
        state_s   = state_r;
        expired_s = expired_r;
        period_s  = period_q_r;
        id_s      = active_id;
        rr_ptr_s  = rr_ptr_r;
        case (state_r)
            S_IDLE: begin
                if (|req) begin
                    id_s     = grant_id_s;
                    period_s = grant_period_s;
                    if (grant_period_s == 32'd0) begin
                        expired_s = 1'b1;
                        state_s   = S_DONE;
                    end else begin
                        expired_s = 1'b0;
                        state_s   = S_WR_PL;
                    end
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_WR_PL:  state_s = S_WR_PH;
            S_WR_PH:  state_s = S_WR_CTL;
            S_WR_CTL: state_s = S_WAIT_IRQ;
            S_WAIT_IRQ: begin
                if (tm_irq) begin
                    expired_s = 1'b1;
                    state_s   = S_WR_STOP;
                end else if (!cur_req_s) begin
                    expired_s = 1'b0;
                    state_s   = S_WR_STOP;
                end else begin
                    state_s = S_WAIT_IRQ;
                end
            end
            S_WR_STOP: state_s = S_CLR_ST;
            S_CLR_ST:  state_s = S_DONE;
            S_DONE: begin
                rr_ptr_s = (active_id == IDW'(NREQ - 1)) ? '0 : active_id + IDW'(1);
                state_s  = S_IDLE;
            end
            default: state_s = S_IDLE;
        endcase
    end

    // Output values for the upcoming state, so every output leaves a flop.
    always_comb begin
        tm_cs_s   = 1'b0;
        tm_wn_s   = 1'b1;
        tm_addr_s = 3'd0;
        tm_data_s = 16'd0;
        case (state_s)
            S_WR_PL:   begin tm_cs_s = 1'b1; tm_wn_s = 1'b0; tm_addr_s = 3'd2; tm_data_s = period_s[15:0];  end
            S_WR_PH:   begin tm_cs_s = 1'b1; tm_wn_s = 1'b0; tm_addr_s = 3'd3; tm_data_s = period_s[31:16]; end
            S_WR_CTL:  begin tm_cs_s = 1'b1; tm_wn_s = 1'b0; tm_addr_s = 3'd1; tm_data_s = 16'h0005;        end
            S_WR_STOP: begin tm_cs_s = 1'b1; tm_wn_s = 1'b0; tm_addr_s = 3'd1; tm_data_s = 16'h0008;        end
            S_CLR_ST:  begin tm_cs_s = 1'b1; tm_wn_s = 1'b0; tm_addr_s = 3'd0; tm_data_s = 16'h0000;        end
            default:   begin tm_cs_s = 1'b0; tm_wn_s = 1'b1; tm_addr_s = 3'd0; tm_data_s = 16'd0;           end
        endcase
        for (int i = 0; i < NREQ; i++) begin
            done_s[i]    = (state_s == S_DONE) && expired_s  && (id_s == IDW'(i));
            aborted_s[i] = (state_s == S_DONE) && !expired_s && (id_s == IDW'(i));
        end
    end

    // State and output registers; the timer shares this reset so no cleanup is needed.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r       <= S_IDLE;
            rr_ptr_r      <= '0;
            period_q_r    <= 32'd0;
            expired_r     <= 1'b0;
            active_id     <= '0;
            busy          <= 1'b0;
            done          <= '0;
            aborted       <= '0;
            tm_chipselect <= 1'b0;
            tm_write_n    <= 1'b1;
            tm_address    <= 3'd0;
            tm_writedata  <= 16'd0;
        end else begin
            state_r       <= state_s;
            rr_ptr_r      <= rr_ptr_s;
            period_q_r    <= period_s;
            expired_r     <= expired_s;
            active_id     <= id_s;
            busy          <= (state_s != S_IDLE);
            done          <= done_s;
            aborted       <= aborted_s;
            tm_chipselect <= tm_cs_s;
            tm_write_n    <= tm_wn_s;
            tm_address    <= tm_addr_s;
            tm_writedata  <= tm_data_s;
        end
    end

endmodule

// File: tb/tb_timer_share_sched.sv
// Randomized bench: transaction-level scheduler model with cycle-stamped expected
// events, plus a behavioural interval-timer slave.
module tb_timer_share_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 3;
    localparam int NCYC = 9000;
    localparam logic [20:0] TM_IDLE = {1'b0, 1'b1, 3'd0, 16'd0};

    logic                clk = 1'b0;
    logic                reset_n = 1'b0;
    logic [NREQ-1:0]     req = '0;
    logic [32*NREQ-1:0]  req_period = '0;
    logic [NREQ-1:0]     done, aborted;
    logic                busy;
    logic [IDW-1:0]      active_id;
    logic [2:0]          tm_address;
    logic                tm_chipselect, tm_write_n;
    logic [15:0]         tm_writedata;
    logic                tm_irq = 1'b0;

    timer_share_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk(clk), .reset_n(reset_n), .req(req), .req_period(req_period),
        .done(done), .aborted(aborted), .busy(busy), .active_id(active_id),
        .tm_address(tm_address), .tm_chipselect(tm_chipselect), .tm_write_n(tm_write_n),
        .tm_writedata(tm_writedata), .tm_irq(tm_irq)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [20:0] wr(input logic [2:0] a, input logic [15:0] d);
        return {1'b1, 1'b0, a, d};
    endfunction

    function automatic int pick(input logic [NREQ-1:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    function automatic logic [31:0] rand_small();
        return ($urandom % 6 == 0) ? 32'd0 : 32'($urandom_range(1, 40));
    endfunction

    // scheduler model
    logic [20:0] exp_wr [int];
    int          exp_done [int];
    int          exp_abort [int];
    int          rr_m = 0, id_m = 0, g_cyc = 0, busy_hi = 0, free_from = 1;
    bit          in_svc = 0, waiting = 0;
    logic [31:0] per_m;
    // requesters and timer slave
    int          drop_at [NREQ];
    logic [31:0] t_per = 0, t_cnt = 0;
    bit          t_run = 0, t_to = 0, t_ito = 0;
    bit          did_rst = 0;
    int          rst_t = -10;

    initial begin
        for (int i = 0; i < NREQ; i++) drop_at[i] = -1;
        for (int t = 0; t < NCYC; t++) begin
            @(negedge clk);
            // outputs for this cycle
            begin
                logic [NREQ-1:0] ed, ea;
                bit eb;
                ed = '0;
                ea = '0;
                if (exp_done.exists(t))  ed[exp_done[t]]  = 1'b1;
                if (exp_abort.exists(t)) ea[exp_abort[t]] = 1'b1;
                eb = in_svc && (t >= g_cyc) && (t <= busy_hi);
                check_eq("tm_bus", {tm_chipselect, tm_write_n, tm_address, tm_writedata},
                         exp_wr.exists(t) ? exp_wr[t] : TM_IDLE);
                check_eq("done", done, ed);
                check_eq("aborted", aborted, ea);
                check_eq("busy", busy, eb);
                if (eb) check_eq("active_id", active_id, id_m);
                else if (t == rst_t + 1) check_eq("active_id_rst", active_id, 0);
            end
            // service completion
            if (in_svc && t == busy_hi) begin
                rr_m   = (id_m + 1) % NREQ;
                in_svc = 0;
                if (req[id_m]) begin
                    if ($urandom % 3 == 0) begin
                        req_period[32*id_m +: 32] = rand_small();
                        drop_at[id_m] = -1;
                    end else begin
                        req[id_m] = 1'b0;
                    end
                end
            end
            // mid-wait reset, then a 1010 request pattern after release
            if (!did_rst && t >= 4000 && in_svc && waiting) begin
                reset_n = 1'b0;
                did_rst = 1;
                rst_t   = t;
                in_svc  = 0;
                waiting = 0;
                rr_m    = 0;
                free_from = t + 2;
                exp_wr.delete();
                exp_done.delete();
                exp_abort.delete();
                t_run = 0; t_to = 0; t_ito = 0; t_per = 0; t_cnt = 0;
                tm_irq = 1'b0;
                req = '0;
                for (int i = 0; i < NREQ; i++) drop_at[i] = -1;
                continue;
            end
            if (t == rst_t + 1 || t == 0) reset_n = 1'b1;
            // timer slave reacting to the write bus
            if (tm_chipselect && !tm_write_n) begin
                case (tm_address)
                    3'd0: t_to = 0;
                    3'd1: begin
                        t_ito = tm_writedata[0];
                        if (tm_writedata[3]) t_run = 0;
                        if (tm_writedata[2]) begin t_run = 1; t_cnt = t_per; end
                    end
                    3'd2: begin t_per[15:0]  = tm_writedata; t_run = 0; end
                    3'd3: begin t_per[31:16] = tm_writedata; t_run = 0; end
                    default: ;
                endcase
            end else if (t_run) begin
                if (t_cnt == 0) begin
                    t_to  = 1;
                    t_run = 0;
                    if (in_svc && waiting && req[id_m] && ($urandom % 3 == 0)) req[id_m] = 1'b0;
                end else begin
                    t_cnt--;
                end
            end
            tm_irq = t_to & t_ito;
            // requesters
            if (t == rst_t + 1) begin
                req = 4'b1010;
                req_period[32*1 +: 32] = 32'($urandom_range(1, 30));
                req_period[32*3 +: 32] = 32'($urandom_range(1, 30));
            end else begin
                for (int i = 0; i < NREQ; i++) begin
                    if (req[i]) begin
                        if (drop_at[i] >= 0 && t >= drop_at[i]) begin
                            req[i] = 1'b0;
                            drop_at[i] = -1;
                        end else if ($urandom % 16 == 0 && drop_at[i] < 0) begin
                            req_period[32*i +: 32] = rand_small();
                        end
                    end else if ($urandom % 10 == 0) begin
                        req[i] = 1'b1;
                        if ($urandom % 5 == 0) begin
                            req_period[32*i +: 32] = {16'($urandom_range(1, 16'hffff)), 16'($urandom)};
                            drop_at[i] = t + $urandom_range(5, 60);
                        end else begin
                            req_period[32*i +: 32] = rand_small();
                            drop_at[i] = ($urandom % 4 == 0) ? t + $urandom_range(1, 60) : -1;
                        end
                    end
                end
            end
            // model decisions for the coming clock edge
            begin
                int e;
                e = t + 1;
                if (in_svc && waiting && e >= g_cyc + 4 && (tm_irq || !req[id_m])) begin
                    exp_wr[e]     = wr(3'd1, 16'h0008);
                    exp_wr[e + 1] = wr(3'd0, 16'h0000);
                    if (tm_irq) exp_done[e + 2] = id_m;
                    else        exp_abort[e + 2] = id_m;
                    busy_hi   = e + 2;
                    free_from = e + 4;
                    waiting   = 0;
                end
                if (!in_svc && reset_n && e >= free_from && req != '0) begin
                    id_m   = pick(req, rr_m);
                    per_m  = req_period[32*id_m +: 32];
                    g_cyc  = e;
                    in_svc = 1;
                    if (per_m == 32'd0) begin
                        exp_done[e] = id_m;
                        busy_hi     = e;
                        free_from   = e + 2;
                        waiting     = 0;
                    end else begin
                        exp_wr[e]     = wr(3'd2, per_m[15:0]);
                        exp_wr[e + 1] = wr(3'd3, per_m[31:16]);
                        exp_wr[e + 2] = wr(3'd1, 16'h0005);
                        busy_hi = 32'h7fff_ffff;
                        waiting = 1;
                    end
                end
            end
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
